// File: rtl/fifo_ctrl_if.sv
// Handshake and RAM-port bundle for fifo_ctrl: producer/consumer requests, RAM strobes and status.
interface fifo_ctrl_if #(
  parameter int ADDR_BITS = 10
) ();
  logic                 en;
  logic                 wr_req;
  logic                 rd_req;
  logic                 mem_wr_en;
  logic [ADDR_BITS-1:0] mem_wr_addr;
  logic                 mem_rd_en;
  logic [ADDR_BITS-1:0] mem_rd_addr;
  logic                 rd_valid;
  logic [ADDR_BITS:0]   usedw;
  logic                 full;
  logic                 empty;
  logic                 perc_full;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output en, wr_req, rd_req,
    input  mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr, rd_valid,
    input  usedw, full, empty, perc_full, overflow, underflow
  );

  modport slave (
    input  en, wr_req, rd_req,
    output mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr, rd_valid,
    output usedw, full, empty, perc_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO sequencer: pointers, occupancy and status flags for an external
// dual-port RAM with a one-cycle registered read.
module fifo_ctrl #(
  parameter int ADDR_BITS    = 10,
  parameter int AFULL_THRESH = 768
) (
  input  logic      clk,
  input  logic      rst,
  fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_W  = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] THRESH_W = (ADDR_BITS + 1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0] ONE_W    = (ADDR_BITS + 1)'(1);

  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic [ADDR_BITS:0] usedw_q;
  logic [ADDR_BITS:0] usedw_next;
  logic               full_q;
  logic               empty_q;
  logic               perc_q;
  logic               overflow_q;
  logic               underflow_q;
  logic               rd_valid_q;
  logic               wr_acc;
  logic               rd_acc;

  // Accept decisions use the registered flags, so a write at full stays refused even
  // when a read is accepted in the same cycle.
  always_comb begin
    wr_acc     = bus.en & bus.wr_req & ~full_q;
    rd_acc     = bus.en & bus.rd_req & ~empty_q;
    usedw_next = usedw_q;
    if (wr_acc && !rd_acc) begin
      usedw_next = usedw_q + ONE_W;
    end else if (rd_acc && !wr_acc) begin
      usedw_next = usedw_q - ONE_W;
    end
  end

  // Flags are decoded from usedw_next so they line up with the registered usedw.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      perc_q      <= (AFULL_THRESH == 0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE_W;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE_W;
      end
      usedw_q    <= usedw_next;
      full_q     <= (usedw_next == DEPTH_W);
      empty_q    <= (usedw_next == '0);
      perc_q     <= (usedw_next >= THRESH_W);
      rd_valid_q <= rd_acc;
      if (bus.en && bus.wr_req && full_q) begin
        overflow_q <= 1'b1;
      end
      if (bus.en && bus.rd_req && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.mem_wr_en   = wr_acc;
  assign bus.mem_rd_en   = rd_acc;
  assign bus.mem_wr_addr = wr_ptr[ADDR_BITS-1:0];
  assign bus.mem_rd_addr = rd_ptr[ADDR_BITS-1:0];
  assign bus.rd_valid    = rd_valid_q;
  assign bus.usedw       = usedw_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.perc_full   = perc_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule
